// File: rtl/bit_cnt_sched.sv
`default_nettype none
// ============================================================================
// Module      : bit_cnt_sched
// Description : Round-robin scheduler that shares one combinational
//               population counter between NREQ valid/ready requesters.
//               A granted word is registered onto cnt_word and held for one
//               full cycle. The counter result is then captured and returned
//               with the requester ID on a valid/ready result port.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_cnt_sched #(
  parameter int NREQ    = 4,
  parameter int BITS    = 64,
  parameter int OUTBITS = 7,
  parameter int IDW     = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*BITS-1:0] req_data,
  output logic [BITS-1:0]      cnt_word,
  input  logic [OUTBITS-1:0]   cnt_bits,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [IDW-1:0]       res_id,
  output logic [OUTBITS-1:0]   res_bits
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_COUNT = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  localparam logic [IDW:0]   NREQ_EXT = (IDW+1)'(NREQ);
  localparam logic [IDW-1:0] LAST_ID  = IDW'(NREQ - 1);

  // --------------------------------------------------------------------------
  // Registers and their next-state values
  // --------------------------------------------------------------------------
  logic [1:0]         state_q,     state_d;
  logic [IDW-1:0]     rr_ptr_q,    rr_ptr_d;
  logic [BITS-1:0]    cnt_word_q,  cnt_word_d;
  logic [IDW-1:0]     id_q,        id_d;
  logic               res_valid_q, res_valid_d;
  logic [IDW-1:0]     res_id_q,    res_id_d;
  logic [OUTBITS-1:0] res_bits_q,  res_bits_d;

  // --------------------------------------------------------------------------
  // Arbitration signals
  // --------------------------------------------------------------------------
  logic               grant_found;
  logic [IDW-1:0]     grant_idx;
  logic [IDW:0]       cand_ext;
  logic               issue_en;
  logic               transfer;
  logic [NREQ-1:0]    req_ready_w;
  logic [BITS-1:0]    granted_word;
  logic [IDW-1:0]     next_ptr;

  // Round-robin search starting at rr_ptr; looks only at req_valid so the
  // grant never depends on any data word.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_ext    = '0;
    for (int k = 0; k < NREQ; k++) begin
      // rr_ptr + k is below 2*NREQ, so one conditional subtract wraps it
      cand_ext = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (cand_ext >= NREQ_EXT) begin
        cand_ext = cand_ext - NREQ_EXT;
      end
      if (!grant_found && req_valid[cand_ext[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand_ext[IDW-1:0];
      end
    end
  end

  // Issue window: idle, or holding a result that is being consumed this
  // cycle (back-to-back issue). Forced closed while reset is asserted.
  always_comb begin
    issue_en = rst_n &&
               ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && res_ready));
    transfer = issue_en && grant_found;
    req_ready_w = '0;
    if (transfer) begin
      req_ready_w[grant_idx] = 1'b1;
    end
  end

  // Select the granted word; unselected requesters never reach cnt_word, so
  // unknown values on their data lanes cannot propagate.
  always_comb begin
    granted_word = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == IDW'(i)) begin
        granted_word = req_data[i*BITS +: BITS];
      end
    end
  end

  // Pointer moves just past the winner, wrapping from the last requester to 0.
  always_comb begin
    if (grant_idx == LAST_ID) begin
      next_ptr = '0;
    end else begin
      next_ptr = grant_idx + IDW'(1);
    end
  end

  // Scheduler FSM next-state and datapath register updates.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    cnt_word_d  = cnt_word_q;
    id_d        = id_q;
    res_valid_d = res_valid_q;
    res_id_d    = res_id_q;
    res_bits_d  = res_bits_q;

    case (state_q)
      ST_IDLE: begin
        if (transfer) begin
          cnt_word_d = granted_word;
          id_d       = grant_idx;
          rr_ptr_d   = next_ptr;
          state_d    = ST_COUNT;
        end
      end

      ST_COUNT: begin
        // cnt_word has been stable for a full cycle; sample the counter.
        res_bits_d  = cnt_bits;
        res_id_d    = id_q;
        res_valid_d = 1'b1;
        state_d     = ST_HOLD;
      end

      ST_HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          if (transfer) begin
            cnt_word_d = granted_word;
            id_d       = grant_idx;
            rr_ptr_d   = next_ptr;
            state_d    = ST_COUNT;
          end else begin
            state_d    = ST_IDLE;
          end
        end
      end

      default: begin
        state_d     = ST_IDLE;
        res_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight or held work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      cnt_word_q  <= '0;
      id_q        <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_bits_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      cnt_word_q  <= cnt_word_d;
      id_q        <= id_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_bits_q  <= res_bits_d;
    end
  end

  assign req_ready = req_ready_w;
  assign cnt_word  = cnt_word_q;
  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_bits  = res_bits_q;

endmodule
`default_nettype wire
